// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, grant encoding and arbitration helpers
// for the common data bus arbiter. The optional round-robin policy is
// selected with the CDB_RR_EN macro in cdb_arbiter.sv.
package cdb_arbiter_pkg;

  // Core-wide defaults for the ROB index and result widths.
  localparam int ROB_IDX_WIDTH = 4;
  localparam int DATA_WIDTH    = 32;

  // One-bit source encoding used by the round-robin history bit.
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  // Per-cycle grant decision.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_ALU  = 2'b01,
    GRANT_LSB  = 2'b10
  } grant_e;

  // Fixed priority: loads win so their dependents wake up sooner.
  function automatic grant_e pick_fixed(input logic alu_v, input logic lsb_v);
    grant_e g;
    case ({lsb_v, alu_v})
      2'b11:   g = GRANT_LSB;
      2'b10:   g = GRANT_LSB;
      2'b01:   g = GRANT_ALU;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

  // Round robin: on a tie the source that did not win last time goes first.
  function automatic grant_e pick_rr(input logic alu_v, input logic lsb_v,
                                     input logic last_grant);
    grant_e g;
    case ({lsb_v, alu_v})
      2'b11:   g = (last_grant == CDB_SRC_LSB) ? GRANT_ALU : GRANT_LSB;
      2'b10:   g = GRANT_LSB;
      2'b01:   g = GRANT_ALU;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: small power-of-two result FIFO feeding one CDB source.
// Push, pop and flush all take effect only while rdy_in is high; flush
// wins over push/pop so rollback never leaves a stale entry behind.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = ROB_IDX_WIDTH + DATA_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: nothing moves while frozen or flushing, and the
  // occupancy guards keep a misbehaving producer from corrupting state.
  always_comb begin
    do_push_s = 1'b0;
    do_pop_s  = 1'b0;
    if (rdy_in && !flush) begin
      do_push_s = push && (count_r != CNT_W'(DEPTH));
      do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    end else begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
    end
  end

  // Entry storage; only the slot under the write pointer changes.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (rdy_in && flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus between the ALU and the LSB.
// Each source has a cdb_fifo; an empty FIFO lets its incoming result
// bypass straight to arbitration. One winner per cycle is registered onto
// the CDB. Define CDB_RR_EN for round-robin arbitration; otherwise the
// LSB has fixed priority over the ALU.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_IDX_W = ROB_IDX_WIDTH,
  parameter int DATA_W    = DATA_WIDTH,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 roll_back,
  input  logic                 alu_en,
  input  logic [ROB_IDX_W-1:0] alu_rob_idx,
  input  logic [DATA_W-1:0]    alu_val,
  output logic                 alu_stall,
  input  logic                 lsb_en,
  input  logic [ROB_IDX_W-1:0] lsb_rob_idx,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 lsb_stall,
  output logic                 cdb_en,
  output logic [ROB_IDX_W-1:0] cdb_rob_idx,
  output logic [DATA_W-1:0]    cdb_val
);

  localparam int ENT_W = ROB_IDX_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ENT_W-1:0] alu_head_s;
  logic [ENT_W-1:0] lsb_head_s;
  logic [ENT_W-1:0] alu_cand_s;
  logic [ENT_W-1:0] lsb_cand_s;
  logic [CNT_W-1:0] alu_count_s;
  logic [CNT_W-1:0] lsb_count_s;
  logic             alu_full_s;
  logic             lsb_full_s;
  logic             alu_empty_s;
  logic             lsb_empty_s;
  logic             alu_cand_v_s;
  logic             lsb_cand_v_s;
  logic             alu_push_s;
  logic             lsb_push_s;
  logic             alu_pop_s;
  logic             lsb_pop_s;
  grant_e           grant_s;

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_alu_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (roll_back),
    .push      (alu_push_s),
    .push_data ({alu_rob_idx, alu_val}),
    .pop       (alu_pop_s),
    .head      (alu_head_s),
    .count     (alu_count_s),
    .full      (alu_full_s)
  );

  cdb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_lsb_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (roll_back),
    .push      (lsb_push_s),
    .push_data ({lsb_rob_idx, lsb_val}),
    .pop       (lsb_pop_s),
    .head      (lsb_head_s),
    .count     (lsb_count_s),
    .full      (lsb_full_s)
  );

  // Stall is a pure decode of the registered count: no credit for a pop
  // happening in the same cycle.
  assign alu_stall = alu_full_s;
  assign lsb_stall = lsb_full_s;

  // Per-source candidate: FIFO head when occupied, else the incoming bypass.
  always_comb begin
    alu_empty_s = (alu_count_s == {CNT_W{1'b0}});
    lsb_empty_s = (lsb_count_s == {CNT_W{1'b0}});
    if (alu_empty_s) begin
      alu_cand_v_s = alu_en;
      alu_cand_s   = {alu_rob_idx, alu_val};
    end else begin
      alu_cand_v_s = 1'b1;
      alu_cand_s   = alu_head_s;
    end
    if (lsb_empty_s) begin
      lsb_cand_v_s = lsb_en;
      lsb_cand_s   = {lsb_rob_idx, lsb_val};
    end else begin
      lsb_cand_v_s = 1'b1;
      lsb_cand_s   = lsb_head_s;
    end
  end

`ifdef CDB_RR_EN
  logic last_grant_r;

  // Remember the last winner; reset/rollback leaves the LSB favoured.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      last_grant_r <= CDB_SRC_ALU;
    end else if (rdy_in) begin
      if (roll_back) begin
        last_grant_r <= CDB_SRC_ALU;
      end else begin
        case (grant_s)
          GRANT_ALU: last_grant_r <= CDB_SRC_ALU;
          GRANT_LSB: last_grant_r <= CDB_SRC_LSB;
          default:   last_grant_r <= last_grant_r;
        endcase
      end
    end
  end

  // Round-robin grant; nothing is granted while frozen or rolling back.
  always_comb begin
    grant_s = GRANT_NONE;
    if (rdy_in && !roll_back) begin
      grant_s = pick_rr(alu_cand_v_s, lsb_cand_v_s, last_grant_r);
    end else begin
      grant_s = GRANT_NONE;
    end
  end
`else
  // Fixed-priority grant; nothing is granted while frozen or rolling back.
  always_comb begin
    grant_s = GRANT_NONE;
    if (rdy_in && !roll_back) begin
      grant_s = pick_fixed(alu_cand_v_s, lsb_cand_v_s);
    end else begin
      grant_s = GRANT_NONE;
    end
  end
`endif

  // Pop the winner's head, or bypass it; any accepted loser is buffered.
  always_comb begin
    alu_pop_s  = (grant_s == GRANT_ALU) && !alu_empty_s;
    lsb_pop_s  = (grant_s == GRANT_LSB) && !lsb_empty_s;
    alu_push_s = alu_en && !alu_full_s && !((grant_s == GRANT_ALU) && alu_empty_s);
    lsb_push_s = lsb_en && !lsb_full_s && !((grant_s == GRANT_LSB) && lsb_empty_s);
  end

  // CDB output registers; index/value hold when there is nothing to send.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      cdb_en      <= 1'b0;
      cdb_rob_idx <= {ROB_IDX_W{1'b0}};
      cdb_val     <= {DATA_W{1'b0}};
    end else if (rdy_in) begin
      if (roll_back) begin
        cdb_en <= 1'b0;
      end else begin
        case (grant_s)
          GRANT_ALU: begin
            cdb_en      <= 1'b1;
            cdb_rob_idx <= alu_cand_s[ENT_W-1 -: ROB_IDX_W];
            cdb_val     <= alu_cand_s[DATA_W-1:0];
          end
          GRANT_LSB: begin
            cdb_en      <= 1'b1;
            cdb_rob_idx <= lsb_cand_s[ENT_W-1 -: ROB_IDX_W];
            cdb_val     <= lsb_cand_s[DATA_W-1:0];
          end
          default: cdb_en <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter with per-source scoreboard
// queues. Expected orderings depend on CDB_RR_EN.
module tb_cdb_arbiter;

  localparam int RW = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [RW-1:0] idx;
    logic [DW-1:0] val;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_in, rdy_in, roll_back;
  logic          alu_en, lsb_en;
  logic [RW-1:0] alu_rob_idx, lsb_rob_idx;
  logic [DW-1:0] alu_val, lsb_val;
  logic          alu_stall, lsb_stall;
  logic          cdb_en;
  logic [RW-1:0] cdb_rob_idx;
  logic [DW-1:0] cdb_val;

  int checks = 0;
  int errors = 0;

  ent_t          alu_q[$];
  ent_t          lsb_q[$];
  logic [RW-1:0] seen[$];
  logic          rdy_q = 1'b0;
  logic          mon_on = 1'b0;
  ent_t          mon_got;
  logic          mon_hit;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .roll_back   (roll_back),
    .alu_en      (alu_en),
    .alu_rob_idx (alu_rob_idx),
    .alu_val     (alu_val),
    .alu_stall   (alu_stall),
    .lsb_en      (lsb_en),
    .lsb_rob_idx (lsb_rob_idx),
    .lsb_val     (lsb_val),
    .lsb_stall   (lsb_stall),
    .cdb_en      (cdb_en),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_val     (cdb_val)
  );

  function automatic ent_t mk(input int i, input int v);
    ent_t e;
    e.idx = i[RW-1:0];
    e.val = v;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remember whether the DUT was enabled at each edge.
  always @(posedge clk) rdy_q <= rdy_in;

  // Scoreboard: every fresh broadcast must be the oldest entry of one source.
  always @(negedge clk) begin
    if (mon_on && rdy_q === 1'b1 && cdb_en === 1'b1) begin
      mon_got = {cdb_rob_idx, cdb_val};
      seen.push_back(cdb_rob_idx);
      mon_hit = 1'b0;
      if (alu_q.size() > 0 && alu_q[0] === mon_got) begin
        void'(alu_q.pop_front());
        mon_hit = 1'b1;
      end else if (lsb_q.size() > 0 && lsb_q[0] === mon_got) begin
        void'(lsb_q.pop_front());
        mon_hit = 1'b1;
      end
      checks++;
      assert (mon_hit) else begin
        errors++;
        $error("FAIL broadcast observed idx=%0h val=%0h expected=head of a source queue",
               cdb_rob_idx, cdb_val);
      end
    end
    if (mon_on && rdy_in === 1'b1 && roll_back === 1'b0) begin
      assert (!((alu_en && alu_stall) || (lsb_en && lsb_stall))) else begin
        errors++;
        $error("FAIL protocol observed en while stalled expected=no push when stalled");
      end
    end
  end

  // Drive one cycle of inputs, record accepted results, advance to edge+1.
  task automatic drive(input logic av, input ent_t a, input logic lv, input ent_t l,
                       input logic rdy, input logic rb);
    alu_en      = av;
    alu_rob_idx = a.idx;
    alu_val     = a.val;
    lsb_en      = lv;
    lsb_rob_idx = l.idx;
    lsb_val     = l.val;
    rdy_in      = rdy;
    roll_back   = rb;
    if (rdy && !rb && av) alu_q.push_back(a);
    if (rdy && !rb && lv) lsb_q.push_back(l);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, mk(0, 0), 1'b0, mk(0, 0), 1'b1, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((alu_q.size() != 0 || lsb_q.size() != 0) && n < 32) begin
      idle();
      n++;
    end
    chk(tag, 64'(alu_q.size() + lsb_q.size()), 64'd0);
    idle();
    idle();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            ai, li;
    logic          av, lv;
    logic [RW-1:0] exp3 [6];
    logic          exp4 [4];
    logic [RW-1:0] hold_idx;
    logic          hold_astall;
    logic [RW-1:0] exp6 [2];

`ifdef CDB_RR_EN
    exp3        = '{4'd8, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3};
    exp4        = '{1'b0, 1'b0, 1'b0, 1'b1};
    hold_idx    = 4'd1;
    hold_astall = 1'b0;
    exp6        = '{4'd9, 4'd2};
`else
    exp3        = '{4'd8, 4'd9, 4'd10, 4'd1, 4'd2, 4'd3};
    exp4        = '{1'b0, 1'b0, 1'b1, 1'b1};
    hold_idx    = 4'd9;
    hold_astall = 1'b1;
    exp6        = '{4'd1, 4'd2};
`endif

    // Reset with active inputs: reset must win.
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
    alu_en = 1'b1; alu_rob_idx = 4'd7; alu_val = 32'hdead;
    lsb_en = 1'b1; lsb_rob_idx = 4'd6; lsb_val = 32'hbeef;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cdb_en", 64'(cdb_en), 64'd0);
    chk("rst_cdb_idx", 64'(cdb_rob_idx), 64'd0);
    chk("rst_cdb_val", 64'(cdb_val), 64'd0);
    chk("rst_alu_stall", 64'(alu_stall), 64'd0);
    chk("rst_lsb_stall", 64'(lsb_stall), 64'd0);
    rst_in = 1'b0;
    alu_en = 1'b0;
    lsb_en = 1'b0;
    mon_on = 1'b1;

    // Single ALU result: one-cycle latency, one-cycle pulse.
    drive(1'b1, mk(3, 32'h11), 1'b0, mk(0, 0), 1'b1, 1'b0);
    chk("t1_en", 64'(cdb_en), 64'd1);
    chk("t1_idx", 64'(cdb_rob_idx), 64'd3);
    chk("t1_val", 64'(cdb_val), 64'h11);
    idle();
    chk("t1_en_drop", 64'(cdb_en), 64'd0);
    chk("t1_val_hold", 64'(cdb_val), 64'h11);

    // Simultaneous results: LSB favoured from reset.
    drive(1'b1, mk(1, 32'hA), 1'b1, mk(2, 32'hB), 1'b1, 1'b0);
    chk("t2_first_idx", 64'(cdb_rob_idx), 64'd2);
    chk("t2_first_val", 64'(cdb_val), 64'hB);
    idle();
    chk("t2_second_en", 64'(cdb_en), 64'd1);
    chk("t2_second_idx", 64'(cdb_rob_idx), 64'd1);
    chk("t2_second_val", 64'(cdb_val), 64'hA);
    idle();
    chk("t2_en_drop", 64'(cdb_en), 64'd0);
    drain("t2_drain");

    // Three back-to-back results per source.
    seen.delete();
    ai = 0; li = 0;
    for (int c = 0; c < 20 && (ai < 3 || li < 3); c++) begin
      av = (ai < 3) && !alu_stall;
      lv = (li < 3) && !lsb_stall;
      drive(av, mk(1 + ai, 32'h200 + ai), lv, mk(8 + li, 32'h100 + li), 1'b1, 1'b0);
      if (av) ai++;
      if (lv) li++;
    end
    chk("t3_sent", 64'(ai + li), 64'd6);
    drain("t3_drain");
    chk("t3_count", 64'(seen.size()), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_order_%0d", k), 64'(seen[k]), 64'(exp3[k]));
    end

    // Backpressure: LSB streams 8 results, ALU offers 4.
    ai = 0; li = 0;
    for (int c = 0; c < 40 && (ai < 4 || li < 8); c++) begin
      if (c < 4) begin
        chk($sformatf("t4_alu_stall_%0d", c), 64'(alu_stall), 64'(exp4[c]));
        chk($sformatf("t4_lsb_stall_%0d", c), 64'(lsb_stall), 64'd0);
      end
      av = (ai < 4) && !alu_stall;
      lv = (li < 8) && !lsb_stall;
      drive(av, mk(4 + ai, 32'h300 + ai), lv, mk(8 + li, 32'h400 + li), 1'b1, 1'b0);
      if (av) ai++;
      if (lv) li++;
    end
    chk("t4_sent", 64'(ai + li), 64'd12);
    drain("t4_drain");

    // Rollback with a full ALU FIFO.
    ai = 0;
    for (int c = 0; c < 8 && !alu_stall; c++) begin
      drive(1'b1, mk(5 + ai, 32'h700 + ai), 1'b1, mk(12 + ai, 32'h800 + ai), 1'b1, 1'b0);
      ai++;
    end
    chk("t5_alu_full", 64'(alu_stall), 64'd1);
    drive(1'b0, mk(0, 0), 1'b1, mk(15, 32'hbad), 1'b1, 1'b1);
    alu_q.delete();
    lsb_q.delete();
    chk("t5_en", 64'(cdb_en), 64'd0);
    chk("t5_alu_stall", 64'(alu_stall), 64'd0);
    chk("t5_lsb_stall", 64'(lsb_stall), 64'd0);
    repeat (4) idle();
    chk("t5_no_stale", 64'(cdb_en), 64'd0);

    // Freeze with buffered results.
    drive(1'b1, mk(1, 32'h501), 1'b1, mk(8, 32'h601), 1'b1, 1'b0);
    drive(1'b1, mk(2, 32'h502), 1'b1, mk(9, 32'h602), 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, mk(0, 0), 1'b1, mk(15, 32'hfee), 1'b0, 1'b0);
      chk($sformatf("t6_en_hold_%0d", c), 64'(cdb_en), 64'd1);
      chk($sformatf("t6_idx_hold_%0d", c), 64'(cdb_rob_idx), 64'(hold_idx));
      chk($sformatf("t6_astall_hold_%0d", c), 64'(alu_stall), 64'(hold_astall));
    end
    seen.delete();
    drain("t6_drain");
    chk("t6_count", 64'(seen.size()), 64'd2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6_order_%0d", k), 64'(seen[k]), 64'(exp6[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
